datapath_rtype_pipe: RTL

- Parametrised, clocked successor to the single-cycle R-type datapath.
- Two-stage pipeline: operand read/decode (D), then execute (E), with result handshake and writeback. Holds a 2^REG_ADDR_W-entry register file.
- Adds valid/ready flow control, backpressure, operand forwarding, illegal-instruction flagging and a retired-instruction counter.
- Sits between the instruction source (bench or future fetch unit) and any result consumer.

---
 rtl/datapath_rtype_pipe.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/datapath_rtype_pipe.sv
// Two-stage (decode/execute) R-type datapath with valid/ready flow control,
// operand forwarding at accept, illegal-instruction flagging and a retire counter.
module datapath_rtype_pipe #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [31:0]           instr,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_W-1:0]     res_data,
    output logic [REG_ADDR_W-1:0] res_rd,
    output logic                  zf,
    output logic                  illegal,
    output logic [CNT_W-1:0]      retired_cnt
);

    localparam int NumRegs = 1 << REG_ADDR_W;

    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnNor = 6'h27;
    localparam logic [5:0] FnSlt = 6'h2A;

    logic [DATA_W-1:0]     rf_q [NumRegs];

    logic                  d_valid_q;
    logic                  d_legal_q;
    logic [5:0]            d_funct_q;
    logic [REG_ADDR_W-1:0] d_rd_q;
    logic [DATA_W-1:0]     d_a_q;
    logic [DATA_W-1:0]     d_b_q;

    logic                  e_valid_q;
    logic [DATA_W-1:0]     e_data_q;
    logic [REG_ADDR_W-1:0] e_rd_q;
    logic                  e_zf_q;
    logic                  e_illegal_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;

    logic [REG_ADDR_W-1:0] in_rs;
    logic [REG_ADDR_W-1:0] in_rt;
    logic [REG_ADDR_W-1:0] in_rd;
    logic [5:0]            in_funct;
    logic                  in_legal;
    logic [DATA_W-1:0]     op_a;
    logic [DATA_W-1:0]     op_b;
    logic [DATA_W-1:0]     d_alu;
    logic                  e_handoff;
    logic                  d_adv;
    logic                  accept;
    logic                  unused_instr;

    assign in_rs    = instr[21 +: REG_ADDR_W];
    assign in_rt    = instr[16 +: REG_ADDR_W];
    assign in_rd    = instr[11 +: REG_ADDR_W];
    assign in_funct = instr[5:0];
    assign unused_instr = ^instr;

    assign e_handoff   = e_valid_q && res_ready;
    assign d_adv       = d_valid_q && (!e_valid_q || e_handoff);
    assign instr_ready = !d_valid_q || d_adv;
    assign accept      = instr_valid && instr_ready;
    assign cnt_d       = cnt_q + CNT_W'(1);

    always_comb begin
        in_legal = 1'b0;
        if (instr[31:26] == 6'h00) begin
            case (in_funct)
                FnAdd, FnSub, FnAnd, FnOr, FnNor, FnSlt: in_legal = 1'b1;
                default:                                 in_legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        d_alu = '0;
        if (d_legal_q) begin
            case (d_funct_q)
                FnAdd:   d_alu = d_a_q + d_b_q;
                FnSub:   d_alu = d_a_q - d_b_q;
                FnAnd:   d_alu = d_a_q & d_b_q;
                FnOr:    d_alu = d_a_q | d_b_q;
                FnNor:   d_alu = ~(d_a_q | d_b_q);
                FnSlt:   d_alu = {{(DATA_W-1){1'b0}}, $signed(d_a_q) < $signed(d_b_q)};
                default: d_alu = '0;
            endcase
        end
    end

    // Newest producer wins: D-stage ALU, then E-stage result, then the register file.
    always_comb begin
        op_a = rf_q[in_rs];
        if (d_valid_q && d_legal_q && d_rd_q == in_rs && d_rd_q != '0) begin
            op_a = d_alu;
        end else if (e_valid_q && !e_illegal_q && e_rd_q == in_rs && e_rd_q != '0) begin
            op_a = e_data_q;
        end
        op_b = rf_q[in_rt];
        if (d_valid_q && d_legal_q && d_rd_q == in_rt && d_rd_q != '0) begin
            op_b = d_alu;
        end else if (e_valid_q && !e_illegal_q && e_rd_q == in_rt && e_rd_q != '0) begin
            op_b = e_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NumRegs; i++) begin
                rf_q[i] <= DATA_W'(i);
            end
            d_valid_q   <= 1'b0;
            d_legal_q   <= 1'b0;
            d_funct_q   <= '0;
            d_rd_q      <= '0;
            d_a_q       <= '0;
            d_b_q       <= '0;
            e_valid_q   <= 1'b0;
            e_data_q    <= '0;
            e_rd_q      <= '0;
            e_zf_q      <= 1'b0;
            e_illegal_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            if (e_handoff) begin
                cnt_q <= cnt_d;
                if (!e_illegal_q && e_rd_q != '0) begin
                    rf_q[e_rd_q] <= e_data_q;
                end
            end

            if (d_adv) begin
                e_valid_q   <= 1'b1;
                e_data_q    <= d_alu;
                e_rd_q      <= d_rd_q;
                e_zf_q      <= d_legal_q && (d_alu == '0);
                e_illegal_q <= !d_legal_q;
            end else if (e_handoff) begin
                e_valid_q <= 1'b0;
            end

            if (accept) begin
                d_valid_q <= 1'b1;
                d_legal_q <= in_legal;
                d_funct_q <= in_funct;
                d_rd_q    <= in_rd;
                d_a_q     <= op_a;
                d_b_q     <= op_b;
            end else if (d_adv) begin
                d_valid_q <= 1'b0;
            end
        end
    end

    assign res_valid   = e_valid_q;
    assign res_data    = e_data_q;
    assign res_rd      = e_rd_q;
    assign zf          = e_zf_q;
    assign illegal     = e_illegal_q;
    assign retired_cnt = cnt_q;

endmodule
